// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, addresses the instruction
// memory and registers the fetched word into the F/D pipeline register.
module fetch_ctrl #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] PC_LO     = 32'h0000_3000,
  parameter logic [31:0] PC_HI     = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        is_branch_d,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [11:0] im_addr,
  input  logic [31:0] im_data,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic        valid_d,
  output logic        adel_d,
  output logic        bd_d
);

  logic [31:0] r_pc_f, r_instr_d, r_pc_d;
  logic        r_valid_d, r_adel_d, r_bd_d;

  logic [31:0] w_pc_f_next, w_instr_d_next, w_pc_d_next;
  logic        w_valid_d_next, w_adel_d_next, w_bd_d_next;
  logic        w_fetch_err;

  // Unsigned 32-bit range and alignment check on the address being fetched.
  assign w_fetch_err = (r_pc_f[1:0] != 2'b00) || (r_pc_f < PC_LO) || (r_pc_f > PC_HI);

  always_comb begin
    w_pc_f_next    = r_pc_f;
    w_instr_d_next = r_instr_d;
    w_pc_d_next    = r_pc_d;
    w_valid_d_next = r_valid_d;
    w_adel_d_next  = r_adel_d;
    w_bd_d_next    = r_bd_d;
    if (exc_req || eret) begin
      // Redirects flush D; eret has no delay slot, so nothing is captured.
      w_pc_f_next    = exc_req ? EXC_ENTRY : epc;
      w_instr_d_next = 32'h0;
      w_pc_d_next    = 32'h0;
      w_valid_d_next = 1'b0;
      w_adel_d_next  = 1'b0;
      w_bd_d_next    = 1'b0;
    end else if (!stall) begin
      w_pc_f_next    = br_taken ? br_target : r_pc_f + 32'd4;
      w_pc_d_next    = r_pc_f;
      w_bd_d_next    = is_branch_d;
      w_valid_d_next = 1'b1;
      w_adel_d_next  = w_fetch_err;
      w_instr_d_next = w_fetch_err ? 32'h0 : im_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_f    <= PC_RESET;
      r_instr_d <= 32'h0;
      r_pc_d    <= 32'h0;
      r_valid_d <= 1'b0;
      r_adel_d  <= 1'b0;
      r_bd_d    <= 1'b0;
    end else begin
      r_pc_f    <= w_pc_f_next;
      r_instr_d <= w_instr_d_next;
      r_pc_d    <= w_pc_d_next;
      r_valid_d <= w_valid_d_next;
      r_adel_d  <= w_adel_d_next;
      r_bd_d    <= w_bd_d_next;
    end
  end

  assign im_addr = r_pc_f[13:2];
  assign pc_f    = r_pc_f;
  assign instr_d = r_instr_d;
  assign pc_d    = r_pc_d;
  assign valid_d = r_valid_d;
  assign adel_d  = r_adel_d;
  assign bd_d    = r_bd_d;

endmodule
